csi_pkt_parser: RTL and testbench
=================================

# csi_pkt_parser

Packet-level parser for the CSI-2 receive path, directly downstream of the packet-header finder. Consumes the aligned 32-bit word stream and its header-select flag. Checks and (optionally) corrects the header ECC, then splits traffic into short-packet events and long-packet payload words with byte-keep. The 16-bit payload CRC is stripped from the payload and reported separately for a later checker.

## Interface
- `WC_W`, 16: word-count width; fixed by CSI-2, exposed only for bench shortening.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `din` in 32: aligned word; byte 0 = `din[7:0]` is first on the wire.
- `din_valid` in 1: `din` is meaningful this cycle.
- `ph_select` in 1: with `din_valid`, `din` is a packet header.
- `sp_valid` out 1: one-cycle pulse, short packet received.
- `sp_dt` out 6: short-packet data type.
- `sp_data` out 16: short-packet data field.
- `pd_valid` out 1: payload word valid.
- `pd_data` out 32: payload bytes, same byte order as `din`.
- `pd_keep` out 4: per-byte valid, contiguous from bit 0.
- `pd_last` out 1: final payload word of the packet.
- `pd_dt` out 8: data identifier (VC+DT) of the current long packet; held stable during the packet.
- `crc_valid` out 1: pulse, all CRC bytes consumed.
- `crc_rx` out 16: received CRC, low byte first on the wire.
- `hdr_err` out 1: pulse, uncorrectable header ECC.
- `hdr_corr` out 1: pulse, header corrected; stuck at 0 without the macro.
- `pkt_abort` out 1: pulse, new header arrived before the long packet completed.

## Operation
- Header decode: DI = `din[7:0]`, WC = `din[23:8]`, ECC = `din[31:24]`. DT = DI[5:0].
- Syndrome = CSI-2 6-bit ECC of `din[23:0]` XOR `din[29:24]`. ECC bits [7:6] are ignored.
- Zero syndrome: header good.
- Nonzero syndrome: header handled per Configuration.
- Short packet (DT 0x00–0x0F): `sp_valid` with `sp_dt`, `sp_data` = WC. Stay in IDLE.
- Long packet (DT ≥ 0x10):
  - Load `rem` = WC + 2 (17-bit) and enter PAYLOAD.
  - Each valid word consumes 4 bytes.
  - Let p = min(4, bytes of payload left).
  - If p > 0: `pd_keep` = low p bits set.
  - `pd_last` is set on the word carrying the final payload byte.
  - CRC bytes are captured by position and may straddle two words.
  - When the last CRC byte is consumed: `crc_valid` pulses and the block returns to IDLE.
  - Bytes after the CRC in that word are discarded.
- WC = 0: no `pd_valid`. CRC occupies bytes 0–1 of the next word.
- States:
  - IDLE: ignore words without `ph_select`.
  - PAYLOAD: count down `rem`.
- `ph_select` in PAYLOAD: `pkt_abort` pulses and the word is decoded as a new header. No `pd_last` or `crc_valid` is emitted for the aborted packet.
- `din_valid` low: no state change and no output pulses.
- `reset` mid-packet: immediate return to IDLE with all outputs 0.

## Timing
- All outputs are registered: 1-cycle latency from the consuming `din_valid` edge.
- No backpressure; the stream is accepted every cycle.
- Reset values: every output 0, `pd_dt` 0, `crc_rx` 0.
- Data outputs hold their last value when their valid is low.
- Same-cycle coincidences:
  - `pd_last` and `crc_valid` both assert when CRC fits in the last payload word.
  - `pkt_abort` may coincide with `sp_valid` or `hdr_err` from the new header.
- Back-to-back headers in consecutive cycles are supported.

## Configuration
- `CSI_ECC_CORRECT_EN` defined:
  - Syndrome matching a single-bit column (24 data + 6 ECC) flips that bit. `hdr_corr` pulses and the corrected header is used.
  - Any other nonzero syndrome raises `hdr_err` and the header is dropped.
- Undefined: any nonzero syndrome raises `hdr_err` and the header is dropped. `hdr_corr` is tied 0.

## Structure
- Package `csi_pkg`:
  - DT constants: FS 0x00, FE 0x01, LS 0x02, LE 0x03, SHORT_MAX 0x0F.
  - State enum.
  - ECC parity-column constants.
- Sub-module `csi_ecc`: combinational syndrome and correction-position decoder (24-bit data, 8-bit ECC in → 6-bit syndrome, correct flag, corrected data out).

## Test plan
- Short packet FS, header 0x??_0001_00 with valid ECC → one `sp_valid`, `sp_dt`=0x00, `sp_data`=0x0001, no `pd_valid`.
- Long packet DI 0x2A, WC 5, payload 11 22 33 44 55, CRC BEEF → words:
  - Word 1: `pd_data`=0x44332211, keep 0xF.
  - Word 2: `pd_data` low byte 0x55, keep 0x1, `pd_last`.
  - Same cycle: `crc_valid`, `crc_rx`=0xBEEF.
- WC 4 → `pd_last` on word 1 with keep 0xF; `crc_valid` on word 2 only; WC 3 → CRC split across words 1/2, `crc_rx` correct.
- Header with bit 9 flipped:
  - With macro: `hdr_corr` and normal decode.
  - Without macro: `hdr_err` and following payload words ignored.
- Two-bit header error → `hdr_err` in both builds, no outputs until next `ph_select`.
- `ph_select` at payload word 2 of WC 100 packet → `pkt_abort`, new header decoded. `din_valid` gaps mid-packet cause no count change. Reset mid-packet → all outputs 0 next cycle.

Source files
------------

// File: rtl/csi_pkg.sv
// ---------------------------------------------------------------------------
// csi_pkg
// Shared definitions for the CSI-2 packet parser:
//   - data-type constants for the short-packet range
//   - parser state enum
//   - ECC parity columns: the 6-bit syndrome produced by a flip of each
//     header data bit (ECC bit k flips syndrome bit k alone)
//   - ecc_calc(): 6-bit CSI-2 header ECC over 24 data bits
// ---------------------------------------------------------------------------
package csi_pkg;

    localparam logic [5:0] DT_FS        = 6'h00;
    localparam logic [5:0] DT_FE        = 6'h01;
    localparam logic [5:0] DT_LS        = 6'h02;
    localparam logic [5:0] DT_LE        = 6'h03;
    localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    // Column code of data bit i, bit k set when data bit i feeds parity P[k].
    // Every column has odd weight, so any two-bit error gives an even-weight
    // syndrome that can never be mistaken for a single-bit column.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    function automatic logic [5:0] ecc_calc(input logic [23:0] data);
        logic [5:0] ecc;
        ecc = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (data[i]) ecc = ecc ^ ECC_COL[i];
        end
        return ecc;
    endfunction

endpackage

// File: rtl/csi_ecc.sv
// ---------------------------------------------------------------------------
// csi_ecc
// Combinational CSI-2 packet-header ECC check and single-bit correction.
// Ports:
//   i_data     [23:0]  header data (DI + WC)
//   i_ecc      [7:0]   received ECC byte; bits [7:6] carry no parity
//   o_syndrome [5:0]   recomputed ECC XOR received ECC[5:0]
//   o_correct          syndrome names exactly one bit (data or ECC)
//   o_data     [23:0]  data with the named data bit flipped back
// ---------------------------------------------------------------------------
module csi_ecc
    import csi_pkg::*;
(
    input  logic [23:0] i_data,
    input  logic [7:0]  i_ecc,
    output logic [5:0]  o_syndrome,
    output logic        o_correct,
    output logic [23:0] o_data
);

    logic [5:0] w_syn;
    logic       w_unused_ecc;

    assign w_syn        = ecc_calc(i_data) ^ i_ecc[5:0];
    assign o_syndrome   = w_syn;
    assign w_unused_ecc = ^i_ecc[7:6];

    // NOTE: every output gets a default before the conditional updates so no
    // path through the block leaves a value unassigned (no latch).
    always_comb begin
        o_data    = i_data;
        // A one-hot syndrome is an error in the ECC byte itself; data is intact.
        o_correct = $onehot(w_syn);
        for (int i = 0; i < 24; i++) begin
            if (w_syn == ECC_COL[i]) begin
                o_data[i] = ~i_data[i];
                o_correct = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csi_pkt_parser.sv
// ---------------------------------------------------------------------------
// csi_pkt_parser
// CSI-2 packet parser: header ECC check, short-packet events, long-packet
// payload words with byte-keep, and CRC extraction.
// Build option: define CSI_ECC_CORRECT_EN to correct single-bit header errors
// (hdr_corr pulses); otherwise any header ECC error drops the header.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   din[31:0], din_valid  aligned word stream, byte 0 first on the wire
//   ph_select             qualifies din as a packet header
//   sp_valid/sp_dt/sp_data                  short-packet event
//   pd_valid/pd_data/pd_keep/pd_last/pd_dt  long-packet payload
//   crc_valid/crc_rx      received payload CRC
//   hdr_err/hdr_corr      header ECC outcome pulses
//   pkt_abort             long packet cut short by a new header
// ---------------------------------------------------------------------------
module csi_pkt_parser
    import csi_pkg::*;
#(
    parameter int WC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic        din_valid,
    input  logic        ph_select,
    output logic        sp_valid,
    output logic [5:0]  sp_dt,
    output logic [15:0] sp_data,
    output logic        pd_valid,
    output logic [31:0] pd_data,
    output logic [3:0]  pd_keep,
    output logic        pd_last,
    output logic [7:0]  pd_dt,
    output logic        crc_valid,
    output logic [15:0] crc_rx,
    output logic        hdr_err,
    output logic        hdr_corr,
    output logic        pkt_abort
);

    // rem counts payload plus the two CRC bytes, so it needs one extra bit.
    localparam int REM_W = WC_W + 1;

    state_t           r_state;
    logic [REM_W-1:0] r_rem;
    logic [7:0]       r_crc_lo;

    logic [5:0]       w_syndrome;
    logic             w_ecc_correct;
    logic [23:0]      w_hdr;
    logic             w_hdr_good;
    logic             w_hdr_fixed;
    logic [REM_W-1:0] w_pay_left;
    logic [2:0]       w_p;
    logic [3:0]       w_keep;
    logic [7:0]       w_crc_lo;
    logic [7:0]       w_crc_hi;
    logic             w_crc_done;

    csi_ecc u_ecc (
        .i_data     (din[23:0]),
        .i_ecc      (din[31:24]),
        .o_syndrome (w_syndrome),
        .o_correct  (w_ecc_correct),
        .o_data     (w_hdr)
    );

`ifdef CSI_ECC_CORRECT_EN
    assign w_hdr_good  = (w_syndrome == 6'h00) || w_ecc_correct;
    assign w_hdr_fixed = (w_syndrome != 6'h00) && w_ecc_correct;
`else
    // With a zero syndrome the corrected data equals the raw data, so the
    // decoder output is safe to use; the correction flag itself goes unused.
    logic w_unused_corr;
    assign w_unused_corr = w_ecc_correct;
    assign w_hdr_good    = (w_syndrome == 6'h00);
    assign w_hdr_fixed   = 1'b0;
`endif

    // Payload bytes still owed (rem minus the CRC) and how many land here.
    assign w_pay_left = (r_rem > REM_W'(2)) ? r_rem - REM_W'(2) : '0;
    assign w_p        = (w_pay_left >= REM_W'(4)) ? 3'd4 : w_pay_left[2:0];
    assign w_crc_done = (r_rem <= REM_W'(4));

    always_comb begin
        case (w_p)
            3'd1:    w_keep = 4'b0001;
            3'd2:    w_keep = 4'b0011;
            3'd3:    w_keep = 4'b0111;
            3'd4:    w_keep = 4'b1111;
            default: w_keep = 4'b0000;
        endcase
    end

    // Byte j of this word sits rem-j bytes from the end of the packet: the
    // CRC low byte is 2 from the end, the high byte is the final one. A low
    // byte that arrives alone (rem = 5) is held in r_crc_lo for the next word.
    always_comb begin
        w_crc_lo = r_crc_lo;
        w_crc_hi = 8'h00;
        for (int j = 0; j < 4; j++) begin
            if (r_rem == REM_W'(j + 2)) w_crc_lo = din[8*j +: 8];
            if (r_rem == REM_W'(j + 1)) w_crc_hi = din[8*j +: 8];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_crc_lo  <= 8'h00;
            sp_valid  <= 1'b0;
            sp_dt     <= 6'h00;
            sp_data   <= 16'h0000;
            pd_valid  <= 1'b0;
            pd_data   <= 32'h0000_0000;
            pd_keep   <= 4'h0;
            pd_last   <= 1'b0;
            pd_dt     <= 8'h00;
            crc_valid <= 1'b0;
            crc_rx    <= 16'h0000;
            hdr_err   <= 1'b0;
            hdr_corr  <= 1'b0;
            pkt_abort <= 1'b0;
        end else begin
            sp_valid  <= 1'b0;
            pd_valid  <= 1'b0;
            pd_last   <= 1'b0;
            crc_valid <= 1'b0;
            hdr_err   <= 1'b0;
            hdr_corr  <= 1'b0;
            pkt_abort <= 1'b0;

            if (din_valid) begin
                if (ph_select) begin
                    // A header always wins, even mid-packet.
                    pkt_abort <= (r_state == ST_PAYLOAD);
                    r_state   <= ST_IDLE;
                    if (!w_hdr_good) begin
                        hdr_err <= 1'b1;
                    end else begin
                        hdr_corr <= w_hdr_fixed;
                        if (w_hdr[5:0] <= DT_SHORT_MAX) begin
                            sp_valid <= 1'b1;
                            sp_dt    <= w_hdr[5:0];
                            sp_data  <= w_hdr[23:8];
                        end else begin
                            pd_dt   <= w_hdr[7:0];
                            r_rem   <= REM_W'(w_hdr[8 +: WC_W]) + REM_W'(2);
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end else if (r_state == ST_PAYLOAD) begin
                    if (w_p != 3'd0) begin
                        pd_valid <= 1'b1;
                        pd_data  <= din;
                        pd_keep  <= w_keep;
                        pd_last  <= (w_pay_left <= REM_W'(4));
                    end
                    r_crc_lo <= w_crc_lo;
                    if (w_crc_done) begin
                        crc_valid <= 1'b1;
                        crc_rx    <= {w_crc_hi, w_crc_lo};
                        r_rem     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_rem <= r_rem - REM_W'(4);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_csi_pkt_parser.sv
// ---------------------------------------------------------------------------
// tb_csi_pkt_parser
// Scoreboard bench for csi_pkt_parser. A byte-level reference model predicts
// the output pulses of every consumed word and queues them with the cycle on
// which they are due; a monitor on the falling edge pops and compares.
// Honours CSI_ECC_CORRECT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_csi_pkt_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din = 32'h0;
    logic        din_valid = 1'b0;
    logic        ph_select = 1'b0;
    logic        sp_valid, pd_valid, pd_last, crc_valid, hdr_err, hdr_corr, pkt_abort;
    logic [5:0]  sp_dt;
    logic [15:0] sp_data, crc_rx;
    logic [31:0] pd_data;
    logic [3:0]  pd_keep;
    logic [7:0]  pd_dt;

    always #5 clk = ~clk;

    csi_pkt_parser #(.WC_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .ph_select (ph_select),
        .sp_valid  (sp_valid),
        .sp_dt     (sp_dt),
        .sp_data   (sp_data),
        .pd_valid  (pd_valid),
        .pd_data   (pd_data),
        .pd_keep   (pd_keep),
        .pd_last   (pd_last),
        .pd_dt     (pd_dt),
        .crc_valid (crc_valid),
        .crc_rx    (crc_rx),
        .hdr_err   (hdr_err),
        .hdr_corr  (hdr_corr),
        .pkt_abort (pkt_abort)
    );

    // Pulse vector bit positions.
    localparam int P_SP = 6, P_PD = 5, P_LAST = 4, P_CRC = 3, P_ERR = 2, P_CORR = 1, P_ABT = 0;

    // Parity equations of the CSI-2 header ECC: P[k] = XOR of data bits in mask k.
    localparam logic [23:0] PMASK [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };

    typedef struct {
        int          due;
        logic [6:0]  pulses;
        logic [5:0]  sp_dt;
        logic [15:0] sp_data;
        logic [31:0] pd_data;
        logic [3:0]  pd_keep;
        logic [7:0]  pd_dt;
        logic [15:0] crc_rx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic [6:0] act_pulses;
    assign act_pulses = {sp_valid, pd_valid, pd_last, crc_valid, hdr_err, hdr_corr, pkt_abort};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_active = 1'b0;
    int          m_wc = 0;
    int          m_pos = 0;
    logic [7:0]  m_di = 8'h00;
    logic [15:0] m_crc = 16'h0000;

    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] e;
        for (int k = 0; k < 6; k++) e[k] = ^(d & PMASK[k]);
        return e;
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [7:0] di, input logic [15:0] wc);
        logic [1:0]  junk;
        logic [23:0] d;
        junk = 2'($urandom);
        d    = {wc, di};
        return {junk, ref_ecc(d), d};
    endfunction

    // Decide header fate by brute force: accept as-is, or (when correction is
    // built in) find the one bit among 30 whose flip makes the ECC consistent.
    task automatic model_hdr(input logic [31:0] w, output bit ok, output bit fixed,
                             output logic [23:0] h);
        logic [29:0] t;
        ok    = 1'b0;
        fixed = 1'b0;
        h     = w[23:0];
        if (ref_ecc(w[23:0]) == w[29:24]) begin
            ok = 1'b1;
        end
`ifdef CSI_ECC_CORRECT_EN
        else begin
            for (int b = 0; b < 30; b++) begin
                t = w[29:0] ^ (30'd1 << b);
                if (!ok && ref_ecc(t[23:0]) == t[29:24]) begin
                    ok    = 1'b1;
                    fixed = 1'b1;
                    h     = t[23:0];
                end
            end
        end
`endif
    endtask

    task automatic model_word(input logic ph, input logic [31:0] w);
        exp_t        e;
        bit          ok, fixed;
        logic [23:0] h;
        e     = '{default: 0};
        e.due = cyc + 1;
        if (ph) begin
            e.pulses[P_ABT] = m_active;
            m_active = 1'b0;
            model_hdr(w, ok, fixed, h);
            if (!ok) begin
                e.pulses[P_ERR] = 1'b1;
            end else begin
                e.pulses[P_CORR] = fixed;
                if (h[5:0] < 6'h10) begin
                    e.pulses[P_SP] = 1'b1;
                    e.sp_dt        = h[5:0];
                    e.sp_data      = h[23:8];
                end else begin
                    m_active = 1'b1;
                    m_wc     = int'(h[23:8]);
                    m_pos    = 0;
                    m_di     = h[7:0];
                end
            end
        end else if (m_active) begin
            // Walk the word byte by byte against the packet byte position.
            for (int j = 0; j < 4; j++) begin
                if (m_active) begin
                    if (m_pos < m_wc) begin
                        e.pd_keep[j]      = 1'b1;
                        e.pd_data[8*j +: 8] = w[8*j +: 8];
                        if (m_pos == m_wc - 1) e.pulses[P_LAST] = 1'b1;
                    end else if (m_pos == m_wc) begin
                        m_crc[7:0] = w[8*j +: 8];
                    end else begin
                        m_crc[15:8]     = w[8*j +: 8];
                        e.pulses[P_CRC] = 1'b1;
                        e.crc_rx        = m_crc;
                        m_active        = 1'b0;
                    end
                    m_pos++;
                end
            end
            if (e.pd_keep != 4'h0) begin
                e.pulses[P_PD] = 1'b1;
                e.pd_dt        = m_di;
            end
        end
        if (e.pulses != 7'h0) q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic v, input logic ph, input logic [31:0] w);
        din_valid = v;
        ph_select = ph;
        din       = w;
        if (v) model_word(ph, w);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), $urandom);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t        e;
        logic [31:0] mask;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (act_pulses != 7'h0) begin
                    if (q.size() == 0) begin
                        check("unexpected_output", {57'h0, act_pulses}, 64'h0);
                    end else begin
                        e = q.pop_front();
                        check("due_cycle", cyc, e.due);
                        check("pulses", {57'h0, act_pulses}, {57'h0, e.pulses});
                        if (e.pulses[P_SP]) begin
                            check("sp_dt", sp_dt, e.sp_dt);
                            check("sp_data", sp_data, e.sp_data);
                        end
                        if (e.pulses[P_PD]) begin
                            for (int j = 0; j < 4; j++) mask[8*j +: 8] = {8{e.pd_keep[j]}};
                            check("pd_keep", pd_keep, e.pd_keep);
                            check("pd_data", pd_data & mask, e.pd_data);
                            check("pd_dt", pd_dt, e.pd_dt);
                        end
                        if (e.pulses[P_CRC]) check("crc_rx", crc_rx, e.crc_rx);
                    end
                end else if (q.size() > 0 && q[0].due < cyc) begin
                    e = q.pop_front();
                    check("missing_output", 64'h0, {57'h0, e.pulses});
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] h;
        int          wc, nw, r, b1, b2;
        logic [7:0]  di;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pulses", {57'h0, act_pulses}, 64'h0);
        check("rst_data", {32'h0, pd_data}, 64'h0);
        check("rst_fields", {30'h0, sp_dt, sp_data, pd_keep, pd_dt}, 64'h0);
        check("rst_crc", crc_rx, 64'h0);
        reset = 1'b0;

        // Frame start short packet, WC 1.
        cycle(1'b1, 1'b1, mk_hdr(8'h00, 16'h0001));
        check("fs_sp_valid", sp_valid, 1);
        check("fs_sp_data", sp_data, 16'h0001);
        idle(1);

        // DI 0x2A, WC 5: payload 11..55, CRC 0xBEEF straddling nothing.
        cycle(1'b1, 1'b1, mk_hdr(8'h2A, 16'd5));
        cycle(1'b1, 1'b0, 32'h4433_2211);
        cycle(1'b1, 1'b0, 32'hA5BE_EF55);
        check("wc5_keep", pd_keep, 4'h1);
        check("wc5_last_crc", {pd_last, crc_valid}, 2'b11);
        check("wc5_crc_rx", crc_rx, 16'hBEEF);
        idle(2);
        check("crc_rx_hold", crc_rx, 16'hBEEF);

        // WC 4: last on word 1, CRC alone on word 2.
        cycle(1'b1, 1'b1, mk_hdr(8'h2B, 16'd4));
        cycle(1'b1, 1'b0, 32'hDDCC_BBAA);
        check("wc4_last_no_crc", {pd_last, crc_valid, pd_keep}, {2'b10, 4'hF});
        cycle(1'b1, 1'b0, 32'h9999_3412);
        check("wc4_crc", {crc_valid, crc_rx}, {1'b1, 16'h3412});

        // WC 3: CRC split across words 1 and 2.
        cycle(1'b1, 1'b1, mk_hdr(8'h24, 16'd3));
        cycle(1'b1, 1'b0, 32'h7803_0201);
        cycle(1'b1, 1'b0, 32'hFFFF_FF56);
        check("wc3_crc", crc_rx, 16'h5678);

        // WC 0: no payload, CRC in bytes 0-1 of the next word.
        cycle(1'b1, 1'b1, mk_hdr(8'h12, 16'd0));
        cycle(1'b1, 1'b0, 32'h1234_CDAB);
        check("wc0_crc", {pd_valid, crc_rx}, {1'b0, 16'hCDAB});

        // Header bit 9 flipped.
        cycle(1'b1, 1'b1, mk_hdr(8'h2B, 16'd4) ^ 32'h0000_0200);
`ifdef CSI_ECC_CORRECT_EN
        check("bit9_corr", {hdr_corr, hdr_err}, 2'b10);
`else
        check("bit9_err", {hdr_corr, hdr_err}, 2'b01);
`endif
        cycle(1'b1, 1'b0, $urandom);
        cycle(1'b1, 1'b0, $urandom);

        // Two-bit header error: dropped in both builds, payload ignored.
        cycle(1'b1, 1'b1, mk_hdr(8'h2C, 16'd6) ^ 32'h0002_0008);
        check("dbl_err", {hdr_corr, hdr_err}, 2'b01);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, $urandom);

        // Abort: WC 100, new short header at payload word 2.
        cycle(1'b1, 1'b1, mk_hdr(8'h1E, 16'd100));
        cycle(1'b1, 1'b0, $urandom);
        cycle(1'b1, 1'b1, mk_hdr(8'h02, 16'h0007));
        check("abort_with_sp", {pkt_abort, sp_valid}, 2'b11);

        // Valid gaps mid-packet.
        cycle(1'b1, 1'b1, mk_hdr(8'h2D, 16'd10));
        for (int i = 0; i < 3; i++) begin
            idle(2);
            cycle(1'b1, 1'b0, $urandom);
        end

        // Reset mid-packet.
        cycle(1'b1, 1'b1, mk_hdr(8'h2E, 16'd40));
        cycle(1'b1, 1'b0, $urandom);
        cycle(1'b1, 1'b0, $urandom);
        @(negedge clk);
        #1;
        reset = 1'b1;
        m_active = 1'b0;
        @(negedge clk);
        check("rst_mid_pulses", {57'h0, act_pulses}, 64'h0);
        check("rst_mid_data", {pd_data, pd_dt, pd_keep, 4'h0, crc_rx}, 64'h0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, $urandom);
        idle(1);

        // Randomized traffic.
        for (int p = 0; p < 250; p++) begin
            if ($urandom_range(0, 99) < 30) begin
                di = {2'($urandom), 2'b00, 4'($urandom)};
                wc = $urandom_range(0, 65535);
            end else begin
                di = {2'($urandom), 6'($urandom_range(16, 63))};
                wc = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 60) : $urandom_range(0, 13);
            end
            h = mk_hdr(di, 16'(wc));
            r = $urandom_range(0, 99);
            b1 = $urandom_range(0, 29);
            b2 = (b1 + $urandom_range(1, 29)) % 30;
            if (r < 8)       h = h ^ (32'd1 << b1);
            else if (r < 12) h = h ^ (32'd1 << b1) ^ (32'd1 << b2);
            cycle(1'b1, 1'b1, h);
            nw = (di[5:0] < 6'h10) ? 0 : (wc + 5) / 4;
            if (nw > 0 && $urandom_range(0, 9) == 0) nw = $urandom_range(0, nw - 1);
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                cycle(1'b1, 1'b0, $urandom);
            end
            if ($urandom_range(0, 4) == 0) cycle(1'b1, 1'b0, $urandom);
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
